fir_sfifo: RTL and testbench
============================

FIR_SFIFO -- requirements
Module: fir_sfifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits; data treated as signed two's complement.
REQ-002 SHALL have parameter DEPTH, default 64, entry count; power of two, 4..1024.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-4, almost_full level.
REQ-004 SHALL have parameter AE_THRESH, default 4, almost_empty level.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge; one clock; reset is synchronous and active-low.
REQ-006 SHALL have port rstn  input  1  synchronous active-low reset.
REQ-007 SHALL have port flush  input  1  synchronous pointer/flag clear.
REQ-008 SHALL have port wen  input  1  write request.
REQ-009 SHALL have port din  input  WIDTH  signed write data.
REQ-010 SHALL have port ren  input  1  read request.
REQ-011 SHALL have port dout  output  WIDTH  signed read data.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-013 SHALL have port level  output  log2(DEPTH)+1  occupied entry count, 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 SHALL accept a write on a rising edge iff wen=1 and full=0 at that edge; the ren value does not affect this.
REQ-016 SHALL accept a read on a rising edge iff ren=1 and empty=0 at that edge.
REQ-017 SHALL maintain read/write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 SHALL update level per edge: +1 on a write only, -1 on a read only, unchanged on both or neither.
REQ-019 SHALL drive flags from registered level: full=(level==DEPTH), empty=(level==0), almost_full=(level>=AF_THRESH), almost_empty=(level<=AE_THRESH).
REQ-020 SHALL deassert empty in the cycle after the edge that accepts the first write; write-to-read latency is 1 cycle.
REQ-021 When full, wen=1 and ren=1: SHALL accept only the read; level becomes DEPTH-1; overflow is set.
REQ-022 When empty, wen=1 and ren=1: SHALL accept only the write; level becomes 1; underflow is set.
REQ-023 SHALL set overflow on any edge with wen=1 and full=1, and underflow on any edge with ren=1 and empty=1; both hold until reset or flush.
REQ-024 Without FWFT, SHALL load dout with the head entry on an accepted-read edge and hold dout otherwise.
REQ-025 flush=1 SHALL zero pointers, level, overflow and underflow on that edge, ignore wen/ren, and leave memory contents and (non-FWFT) dout unchanged.
REQ-026 Priority SHALL be rstn > flush > wen/ren.

Reset
REQ-027 On an edge with rstn=0, SHALL clear pointers, level, dout, overflow and underflow; empty=1, almost_empty=1, full=0, almost_full=0 from the next cycle.
REQ-028 Reset asserted mid-stream SHALL discard all stored entries; memory contents need not be cleared.

Configuration
REQ-029 Macro FIR_SFIFO_FWFT_EN defined: dout SHALL combinationally show the head entry whenever empty=0; an accepted read SHALL advance dout to the next entry in the following cycle; dout is don't-care when empty=1.
REQ-030 Macro FIR_SFIFO_FWFT_EN undefined: the registered read behaviour of REQ-024 SHALL apply.

Structure
REQ-031 SHALL take default WIDTH/DEPTH constants and a clog2-based address-width function from shared package fir_pkg.
REQ-032 SHALL place storage in one sub-module fir_sfifo_mem: a 1-write, 1-read register array with synchronous write and asynchronous read.

Verification
REQ-033 Reset, then write 64 values -> full=1, level=64, almost_full asserted at level 60, overflow=0.
REQ-034 Full FIFO with a 65th write (wen=1) -> write ignored, overflow=1, level=64, and the first read returns the first value written.
REQ-035 Read 64 entries (non-FWFT) -> each dout matches write order one cycle after its read edge, empty=1 after the last read, then ren=1 -> underflow=1.
REQ-036 level=64 with wen=ren=1 -> level=63; level=0 with wen=ren=1 -> level=1 and underflow=1.
REQ-037 Write 10 entries, pulse flush -> level=0, empty=1, errors cleared; write 0x7FFF then read -> 0x7FFF.
REQ-038 FWFT build: write -5 -> dout=-5 in the cycle after the write edge with no ren; write 3 and read once -> dout=3 the next cycle.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR sample-path blocks.
package fir_pkg;

    localparam int FIR_WIDTH = 16;
    localparam int FIR_DEPTH = 64;

    // Address width for a given entry count, never less than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fir_sfifo_mem.sv
// Register-array storage for fir_sfifo: one synchronous write port, one asynchronous read port.
module fir_sfifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_sfifo.sv
// Synchronous sample FIFO with level-derived flags and sticky overflow/underflow.
// Define FIR_SFIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module fir_sfifo
    import fir_pkg::*;
#(
    parameter int WIDTH     = FIR_WIDTH,
    parameter int DEPTH     = FIR_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           flush,
    input  logic                           wen,
    input  logic signed [WIDTH-1:0]        din,
    input  logic                           ren,
    output logic signed [WIDTH-1:0]        dout,
    output logic                           full,
    output logic                           empty,
    output logic                           almost_full,
    output logic                           almost_empty,
    output logic [addr_width(DEPTH):0]     level,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int AW = addr_width(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_THRESH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    level_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    assign full         = (level_q == LVL_FULL);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= LVL_AF);
    assign almost_empty = (level_q <= LVL_AE);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wen && !full;
    assign rd_acc = ren && !empty;

    fir_sfifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && rstn && !flush),
        .waddr (wptr),
        .wdata (din),
        .raddr (rptr),
        .rdata (rd_data)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr        <= '0;
            rptr        <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush) begin
            wptr        <= '0;
            rptr        <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - 1'b1;
            end
            if (wen && full) begin
                overflow_q <= 1'b1;
            end
            if (ren && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

`ifdef FIR_SFIFO_FWFT_EN
    assign dout = rd_data;
`else
    logic [WIDTH-1:0] dout_q;

    // Flush leaves the last delivered sample visible.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_q <= '0;
        end else if (!flush && rd_acc) begin
            dout_q <= rd_data;
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_fir_sfifo.sv
// Self-checking bench for fir_sfifo: scoreboard queue plus reference level/flag model.
module tb_fir_sfifo;

    localparam int DEPTH = 64;
    localparam int AFT   = DEPTH - 4;
    localparam int AET   = 4;

    logic               clk;
    logic               rstn;
    logic               flush;
    logic               wen;
    logic signed [15:0] din;
    logic               ren;
    logic signed [15:0] dout;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic [6:0]         level;
    logic               overflow;
    logic               underflow;

    int                 total;
    int                 bad;
    int                 mlevel;
    logic               movf;
    logic               munf;
    logic signed [15:0] mdout;
    logic signed [15:0] sbq [$];

    fir_sfifo dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .wen          (wen),
        .din          (din),
        .ren          (ren),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one clock of stimulus and advances the reference model across that edge.
    task automatic applyStimulus(input logic w, input logic signed [15:0] d,
                                 input logic r, input logic f);
        logic wa;
        logic ra;
        wen   = w;
        din   = d;
        ren   = r;
        flush = f;
        @(posedge clk);
        if (f) begin
            mlevel = 0;
            movf   = 1'b0;
            munf   = 1'b0;
            sbq.delete();
        end else begin
            wa = w && (mlevel < DEPTH);
            ra = r && (mlevel > 0);
            if (w && mlevel == DEPTH) movf = 1'b1;
            if (r && mlevel == 0) munf = 1'b1;
            if (ra) mdout = sbq.pop_front();
            if (wa) sbq.push_back(d);
            mlevel = mlevel + int'(wa) - int'(ra);
        end
        #1;
        wen   = 1'b0;
        ren   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        mlevel = 0;
        movf   = 1'b0;
        munf   = 1'b0;
        mdout  = '0;
        sbq.delete();
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(mlevel));
        chk({tag, ".full"}, 32'(full), 32'(mlevel == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(mlevel == 0));
        chk({tag, ".afull"}, 32'(almost_full), 32'(mlevel >= AFT));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(mlevel <= AET));
        chk({tag, ".ovf"}, 32'(overflow), 32'(movf));
        chk({tag, ".unf"}, 32'(underflow), 32'(munf));
`ifdef FIR_SFIFO_FWFT_EN
        if (mlevel > 0) chk({tag, ".dout"}, 32'(dout), 32'(sbq[0]));
`else
        chk({tag, ".dout"}, 32'(dout), 32'(mdout));
`endif
    endtask

    initial begin
        logic signed [15:0] first;
        total = 0;
        bad   = 0;
        rstn  = 1'b1;
        flush = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        din   = '0;
        mlevel = 0;
        movf  = 1'b0;
        munf  = 1'b0;
        mdout = '0;
        #2;
        doReset();
        doReset();
        $display("[TB] reset state");
        checkOutput("reset");
        chk("reset.dout_zero", 32'(dout), 32'h0);

        $display("[TB] fill to full");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 16'(i * 517 - 9000), 1'b0, 1'b0);
            checkOutput($sformatf("fill%0d", i));
        end
        chk("fill.full_const", 32'(full), 32'h1);
        chk("fill.level_const", 32'(level), 32'd64);
        first = 16'(-9000);

        $display("[TB] overflow write");
        applyStimulus(1'b1, 16'sh1234, 1'b0, 1'b0);
        checkOutput("ovf_write");
        chk("ovf.flag_const", 32'(overflow), 32'h1);

        $display("[TB] simultaneous read/write at full");
        applyStimulus(1'b1, 16'sh1111, 1'b1, 1'b0);
        checkOutput("full_rw");
        chk("full_rw.level_const", 32'(level), 32'd63);
`ifndef FIR_SFIFO_FWFT_EN
        chk("full_rw.first_value", 32'(dout), 32'(first));
`endif
        applyStimulus(1'b1, 16'sh2222, 1'b0, 1'b0);
        checkOutput("refill");

        $display("[TB] drain");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
            checkOutput($sformatf("drain%0d", i));
        end
        chk("drain.empty_const", 32'(empty), 32'h1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("unf_read");
        chk("unf.flag_const", 32'(underflow), 32'h1);

        $display("[TB] simultaneous read/write at empty");
        doReset();
        applyStimulus(1'b1, 16'sh0055, 1'b1, 1'b0);
        checkOutput("empty_rw");
        chk("empty_rw.level_const", 32'(level), 32'd1);
        chk("empty_rw.unf_const", 32'(underflow), 32'h1);

        $display("[TB] flush");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'(i + 40), 1'b0, 1'b0);
        end
        checkOutput("pre_flush");
        applyStimulus(1'b1, 16'sh0999, 1'b1, 1'b1);
        checkOutput("flush");
        applyStimulus(1'b1, 16'sh7FFF, 1'b0, 1'b0);
        checkOutput("post_flush_wr");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("post_flush_rd");
`ifndef FIR_SFIFO_FWFT_EN
        chk("flush.7fff", 32'(dout), 32'(16'sh7FFF));
`endif

        $display("[TB] fall-through ordering");
        applyStimulus(1'b1, -16'sd5, 1'b0, 1'b0);
        checkOutput("fw_m5");
`ifdef FIR_SFIFO_FWFT_EN
        chk("fwft.m5", 32'(dout), 32'(-16'sd5));
`endif
        applyStimulus(1'b1, 16'sd3, 1'b0, 1'b0);
        checkOutput("fw_3");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("fw_rd");
`ifdef FIR_SFIFO_FWFT_EN
        chk("fwft.3", 32'(dout), 32'(16'sd3));
`else
        chk("reg.m5", 32'(dout), 32'(-16'sd5));
`endif

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'(i * 7), 1'b0, 1'b0);
        end
        doReset();
        checkOutput("midreset");
        applyStimulus(1'b1, 16'sh0ABC, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("midreset_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
